// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for an external 8-bit ALU: holds accumulator A and operand B,
// steers the ALU inputs and latches its result and flags, one command at a time.
module alu_cmd_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] alu_ra,
    output logic [WIDTH-1:0] alu_rb,
    output logic             alu_s,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_carry,
    input  logic             alu_zero,
    output logic [WIDTH-1:0] acc,
    output logic             flag_c,
    output logic             flag_z,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_data
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EXEC = 1'b1;

    localparam logic [2:0] OP_LDA  = 3'd0;
    localparam logic [2:0] OP_LDB  = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_ADDI = 3'd4;
    localparam logic [2:0] OP_SUBI = 3'd5;
    localparam logic [2:0] OP_RDA  = 3'd6;
    localparam logic [2:0] OP_CLR  = 3'd7;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             s_q, s_d;
    logic             c_q, c_d;
    logic             z_q, z_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

    // Next-state and datapath decode for IDLE command acceptance and EXEC capture.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        s_d         = s_q;
        c_d         = c_q;
        z_d         = z_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_LDA: begin
                            a_d         = cmd_data;
                            rsp_data_d  = cmd_data;
                            rsp_valid_d = 1'b1;
                        end
                        OP_LDB: begin
                            b_d         = cmd_data;
                            rsp_data_d  = cmd_data;
                            rsp_valid_d = 1'b1;
                        end
                        OP_ADD: begin
                            s_d     = 1'b0;
                            state_d = ST_EXEC;
                        end
                        OP_SUB: begin
                            s_d     = 1'b1;
                            state_d = ST_EXEC;
                        end
                        OP_ADDI: begin
                            s_d     = 1'b0;
                            b_d     = cmd_data;
                            state_d = ST_EXEC;
                        end
                        OP_SUBI: begin
                            s_d     = 1'b1;
                            b_d     = cmd_data;
                            state_d = ST_EXEC;
                        end
                        OP_RDA: begin
                            rsp_data_d  = a_q;
                            rsp_valid_d = 1'b1;
                        end
                        OP_CLR: begin
                            a_d         = {WIDTH{1'b0}};
                            b_d         = {WIDTH{1'b0}};
                            c_d         = 1'b0;
                            z_d         = 1'b0;
                            rsp_data_d  = {WIDTH{1'b0}};
                            rsp_valid_d = 1'b1;
                        end
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            // Operands have been stable for a full cycle; take the ALU result.
            ST_EXEC: begin
                a_d         = alu_out;
                c_d         = alu_carry;
                z_d         = alu_zero;
                rsp_data_d  = alu_out;
                rsp_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; reset in EXEC drops the pending op.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            a_q         <= {WIDTH{1'b0}};
            b_q         <= {WIDTH{1'b0}};
            s_q         <= 1'b0;
            c_q         <= 1'b0;
            z_q         <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= {WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            s_q         <= s_d;
            c_q         <= c_d;
            z_q         <= z_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign alu_ra    = a_q;
    assign alu_rb    = b_q;
    assign alu_s     = s_q;
    assign acc       = a_q;
    assign flag_c    = c_q;
    assign flag_z    = z_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: behavioural ALU stub plus an
// abstract register/flag model, directed scenarios and randomized command streams.
module tb_alu_cmd_sequencer;

    localparam int WIDTH = 8;

    localparam logic [2:0] LDA = 3'd0, LDB = 3'd1, ADD = 3'd2, SUB = 3'd3;
    localparam logic [2:0] ADDI = 3'd4, SUBI = 3'd5, RDA = 3'd6, CLR = 3'd7;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [WIDTH-1:0] alu_ra, alu_rb;
    logic             alu_s;
    logic [WIDTH-1:0] alu_out;
    logic             alu_carry, alu_zero;
    logic [WIDTH-1:0] acc;
    logic             flag_c, flag_z;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_data;

    int checks   = 0;
    int failures = 0;

    // Reference state: what A, B and the flags should be after each command.
    int m_a, m_b, m_c, m_z;

    alu_cmd_sequencer #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data),
        .alu_ra(alu_ra), .alu_rb(alu_rb), .alu_s(alu_s),
        .alu_out(alu_out), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .acc(acc), .flag_c(flag_c), .flag_z(flag_z),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data)
    );

    always #5 clk = ~clk;

    // External ALU stub.
    logic [WIDTH:0] alu_wide;
    always_comb begin
        if (alu_s) begin
            alu_wide  = {1'b0, alu_ra} - {1'b0, alu_rb};
            alu_carry = ~alu_wide[WIDTH];
        end else begin
            alu_wide  = {1'b0, alu_ra} + {1'b0, alu_rb};
            alu_carry = alu_wide[WIDTH];
        end
        alu_out  = alu_wide[WIDTH-1:0];
        alu_zero = (alu_wide[WIDTH-1:0] == 8'd0);
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Apply one command to the reference model; returns response and whether it takes two cycles.
    task automatic model_cmd(input logic [2:0] op, input int data, output int rsp, output bit two);
        int r;
        two = 1'b0;
        rsp = 0;
        case (op)
            LDA: begin m_a = data; rsp = data; end
            LDB: begin m_b = data; rsp = data; end
            RDA: rsp = m_a;
            CLR: begin m_a = 0; m_b = 0; m_c = 0; m_z = 0; rsp = 0; end
            ADD, ADDI, SUB, SUBI: begin
                two = 1'b1;
                if (op == ADDI || op == SUBI) m_b = data;
                if (op == ADD || op == ADDI) begin
                    r   = m_a + m_b;
                    m_c = (r > 255) ? 1 : 0;
                end else begin
                    r   = m_a - m_b;
                    m_c = (m_a >= m_b) ? 1 : 0;
                end
                r   = (r + 256) % 256;
                m_z = (r == 0) ? 1 : 0;
                m_a = r;
                rsp = r;
            end
            default: rsp = 0;
        endcase
    endtask

    // Issue one command and check handshake, response timing and resulting registers.
    task automatic do_cmd(input logic [2:0] op, input int data);
        int  exp_rsp;
        bit  two;
        int  exp_s;
        @(negedge clk);
        chk("rsp_valid idle before cmd", rsp_valid, 0);
        chk("cmd_ready idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data[WIDTH-1:0];
        exp_s     = (op == SUB || op == SUBI) ? 1 : 0;
        model_cmd(op, data, exp_rsp, two);
        @(negedge clk);
        cmd_valid = 1'b0;
        if (two) begin
            chk("rsp_valid low in exec", rsp_valid, 0);
            chk("cmd_ready low in exec", cmd_ready, 0);
            chk("alu_s in exec", alu_s, exp_s);
            chk("alu_rb in exec", alu_rb, m_b);
            @(negedge clk);
            chk("cmd_ready after exec", cmd_ready, 1);
        end
        chk("rsp_valid pulse", rsp_valid, 1);
        chk("rsp_data", rsp_data, exp_rsp);
        chk("acc", acc, m_a);
        chk("alu_ra", alu_ra, m_a);
        chk("alu_rb", alu_rb, m_b);
        chk("flag_c", flag_c, m_c);
        chk("flag_z", flag_z, m_z);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = 3'd0;
        cmd_data = 8'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_a = 0; m_b = 0; m_c = 0; m_z = 0;
        chk("reset acc", acc, 0);
        chk("reset flag_c", flag_c, 0);
        chk("reset flag_z", flag_z, 0);
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset rsp_data", rsp_data, 0);
        chk("reset cmd_ready", cmd_ready, 1);
        chk("reset alu_s", alu_s, 0);
        chk("reset alu_rb", alu_rb, 0);
    endtask

    task automatic test_directed();
        do_cmd(LDA, 144);
        do_cmd(LDB, 89);
        do_cmd(ADD, 0);
        chk("add 144+89", acc, 233);
        do_cmd(LDA, 240);
        do_cmd(SUBI, 240);
        chk("subi equal zero", flag_z, 1);
        chk("subi equal carry", flag_c, 1);
        do_cmd(LDA, 255);
        do_cmd(ADDI, 17);
        chk("addi wrap acc", acc, 16);
        chk("addi wrap carry", flag_c, 1);
        do_cmd(LDA, 7);
        do_cmd(SUBI, 10);
        chk("subi borrow acc", acc, 253);
        chk("subi borrow carry", flag_c, 0);
        do_cmd(RDA, 0);
        do_cmd(CLR, 0);
        chk("clr acc", acc, 0);
    endtask

    // ADD then SUB with cmd_valid held throughout: two pulses two cycles apart.
    task automatic test_back_to_back();
        int pulses;
        int first_at;
        int second_at;
        do_cmd(LDA, 10);
        do_cmd(LDB, 10);
        pulses = 0; first_at = -1; second_at = -1;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = ADD;
        cmd_data  = 8'd0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            if (cyc == 1) cmd_op = SUB;
            if (cyc == 3) cmd_valid = 1'b0;
            if (rsp_valid === 1'b1) begin
                pulses++;
                if (pulses == 1) begin
                    first_at = cyc;
                    chk("b2b add result", rsp_data, 20);
                end else begin
                    second_at = cyc;
                    chk("b2b sub result", rsp_data, 10);
                end
            end
        end
        chk("b2b pulse count", pulses, 2);
        chk("b2b first pulse cycle", first_at, 2);
        chk("b2b pulse spacing", second_at - first_at, 2);
        chk("b2b final acc", acc, 10);
        m_a = 10; m_b = 10; m_c = 1; m_z = 0;
        chk("b2b flag_c", flag_c, m_c);
    endtask

    // Reset landing on the EXEC cycle aborts the ADD.
    task automatic test_reset_in_exec();
        int pulses;
        do_cmd(LDA, 4);
        do_cmd(LDB, 2);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = ADD;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("pre-abort cmd_ready", cmd_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_a = 0; m_b = 0; m_c = 0; m_z = 0;
        chk("abort rsp_valid", rsp_valid, 0);
        chk("abort acc", acc, 0);
        chk("abort flag_c", flag_c, 0);
        chk("abort flag_z", flag_z, 0);
        chk("abort cmd_ready", cmd_ready, 1);
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) pulses++;
        end
        chk("abort no late pulse", pulses, 0);
        do_cmd(RDA, 0);
        chk("rda after abort", rsp_data, 0);
    endtask

    task automatic test_random();
        logic [2:0] op;
        int data;
        for (int i = 0; i < 60; i++) begin
            op   = 3'($urandom_range(7, 0));
            data = int'($urandom_range(255, 0));
            if (op == CLR && ($urandom_range(3, 0) != 0)) op = ADD;
            do_cmd(op, data);
            if ($urandom_range(1, 0) == 1) @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = 3'd0;
        cmd_data = 8'd0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_in_exec();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
